frequency_generator: RTL
========================

FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

Interface
REQ-001 Parameter UPDATE_PERIOD, default 1200, SHALL be the reset value of the generation window length in clk cycles.
REQ-002 Parameter BITS, default 12, SHALL be the width of period, the window counter and the active-period register.
REQ-003 Clocking: one clock; reset is synchronous and active-high (ports clk and reset).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 tens  input  4  BCD tens digit of the target edge count.
REQ-007 units  input  4  BCD units digit of the target edge count.
REQ-008 load  input  1  one-cycle strobe that samples tens/units and restarts generation.
REQ-009 period  input  BITS  new window length in cycles.
REQ-010 period_load  input  1  strobe that samples period into update_period.
REQ-011 signal  output  1  registered generated square wave.
REQ-012 busy  output  1  high while a BCD conversion is in progress.
REQ-013 window_start  output  1  one-cycle pulse on the first cycle of every generation window.

Function
REQ-014 States SHALL be IDLE, CONVERT and RUN; encoding SHALL come from the shared package.
REQ-015 A digit above 9 SHALL saturate to 9 when sampled, so N is always 0..99.
REQ-016 load SHALL be accepted in any state: latch saturated digits, clear count, force signal to 0, clear window_start and go to CONVERT; it takes priority over RUN activity in the same cycle.
REQ-017 CONVERT SHALL add 10 to count and decrement the remaining tens once per cycle while tens remain, then add units in one cycle and enter RUN, so busy is high for exactly tens+1 cycles.
REQ-018 On RUN entry, the window counter and accumulator SHALL be 0 and active_period SHALL be loaded from update_period.
REQ-019 Each RUN cycle SHALL compute acc+2N in BITS+1 bits; if the sum is >= active_period, subtract active_period and toggle signal, otherwise store the sum.
REQ-020 If 2N < active_period, each window SHALL contain exactly 2N toggles (N rising edges) and signal SHALL be 0 at every window boundary.
REQ-021 If 2N >= active_period, signal SHALL toggle every cycle (saturated); no error is flagged.
REQ-022 When the window counter equals active_period-1, it SHALL wrap to 0, acc SHALL clear, signal SHALL be driven 0 and active_period SHALL reload from update_period.
REQ-023 window_start SHALL be high exactly on cycles where the window counter is 0 in RUN.
REQ-024 period_load SHALL update update_period on the next edge; a period value below 2 SHALL be ignored, and the new value takes effect only at the next window start.
REQ-025 With N=0, signal SHALL remain 0 and windows SHALL still run.
REQ-026 IDLE SHALL hold signal=0, busy=0 and window_start=0 until the first load.

Reset
REQ-027 Reset SHALL force IDLE, signal=0, busy=0, window_start=0, count=0, acc=0, window counter=0 and update_period=active_period=UPDATE_PERIOD, overriding load, period_load and any state, including mid-CONVERT or mid-RUN.

Structure
REQ-028 The shared package SHALL hold the state typedef, UPDATE_PERIOD default, BITS default, MAX_COUNT=99 and the digit saturation limit 9.
REQ-029 The BCD-to-binary iterative converter SHALL be a sub-module named bcd_to_bin (start/done handshake); the accumulator and window logic stay in the top.

Verification
REQ-030 Reset, load tens=2 units=5, default period -> busy high 3 cycles, then 25 rising edges per 1200-cycle window, signal=0 at each window_start.
REQ-031 Load tens=0 units=0 -> signal constant 0; window_start every 1200 cycles.
REQ-032 Load tens=0xC units=0xF -> treated as 99: busy 10 cycles; with period_load 200 applied before load, 99 rising edges per 200-cycle window.
REQ-033 In RUN with N=10, period_load 600 mid-window -> current window completes at 1200 cycles, next windows are 600 cycles with 10 edges each.
REQ-034 Load tens=4 units=0 at window cycle 500, then reset asserted during CONVERT -> outputs at reset values next cycle, IDLE, no edges until a new load.
REQ-035 Period 100 with N=60 (2N>=P) -> signal toggles every cycle and window_start still pulses every 100 cycles.

Source files
------------

// File: rtl/frequency_generator_pkg.sv
// rtl/frequency_generator_pkg.sv - shared state encoding, defaults and digit saturation
package frequency_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_RUN     = 2'd2
    } fg_state_t;

    localparam int DEFAULT_UPDATE_PERIOD = 1200;
    localparam int DEFAULT_BITS          = 12;
    localparam int MAX_COUNT             = 99;
    localparam int DIGIT_MAX             = 9;
    localparam int COUNT_W               = $clog2(MAX_COUNT + 1);

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > 4'(DIGIT_MAX)) ? 4'(DIGIT_MAX) : d;
    endfunction

endpackage

// File: rtl/frequency_generator_bcd_to_bin.sv
// rtl/frequency_generator_bcd_to_bin.sv - iterative BCD to binary converter, one ten per cycle
module bcd_to_bin
    import frequency_generator_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [3:0]         i_tens,
    input  logic [3:0]         i_units,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_value
);

    logic [3:0]         r_rem_tens;
    logic [3:0]         r_units;
    logic               r_busy;
    logic [COUNT_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem_tens <= 4'd0;
            r_units    <= 4'd0;
            r_busy     <= 1'b0;
            r_value    <= '0;
        end else if (i_start) begin
            r_rem_tens <= sat_digit(i_tens);
            r_units    <= sat_digit(i_units);
            r_value    <= '0;
            r_busy     <= 1'b1;
        end else if (r_busy) begin
            if (r_rem_tens != 4'd0) begin
                r_value    <= r_value + COUNT_W'(10);
                r_rem_tens <= r_rem_tens - 4'd1;
            end else begin
                r_value <= r_value + COUNT_W'(r_units);
                r_busy  <= 1'b0;
            end
        end
    end

    // Done marks the final (units) cycle; the result is valid from the next cycle on.
    assign o_done  = r_busy && (r_rem_tens == 4'd0);
    assign o_value = r_value;

endmodule

// File: rtl/frequency_generator.sv
// rtl/frequency_generator.sv - windowed square-wave generator producing N rising edges per window
module frequency_generator
    import frequency_generator_pkg::*;
#(
    parameter int UPDATE_PERIOD = DEFAULT_UPDATE_PERIOD,
    parameter int BITS          = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      tens,
    input  logic [3:0]      units,
    input  logic            load,
    input  logic [BITS-1:0] period,
    input  logic            period_load,
    output logic            signal,
    output logic            busy,
    output logic            window_start
);

    localparam int SUM_W = BITS + 1;

    fg_state_t          r_state;
    fg_state_t          w_next_state;
    logic               r_signal;
    logic [BITS-1:0]    r_acc;
    logic [BITS-1:0]    r_win;
    logic [BITS-1:0]    r_update_period;
    logic [BITS-1:0]    r_active_period;

    logic               w_conv_done;
    logic [COUNT_W-1:0] w_n;
    logic [SUM_W-1:0]   w_two_n;
    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   w_period_ext;
    logic [BITS-1:0]    w_remainder;
    logic               w_saturated;
    logic               w_window_end;

    bcd_to_bin u_bcd_to_bin (
        .clk     (clk),
        .reset   (reset),
        .i_start (load),
        .i_tens  (tens),
        .i_units (units),
        .o_done  (w_conv_done),
        .o_value (w_n)
    );

    assign w_two_n      = SUM_W'({w_n, 1'b0});
    assign w_period_ext = {1'b0, r_active_period};
    assign w_sum        = {1'b0, r_acc} + w_two_n;
    // Without saturation acc+2N < 2*period, so the true difference fits in BITS.
    assign w_remainder  = w_sum[BITS-1:0] - r_active_period;
    assign w_saturated  = (w_two_n >= w_period_ext);
    assign w_window_end = (r_win == (r_active_period - BITS'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (load) begin
            w_next_state = ST_CONVERT;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_IDLE;
                ST_CONVERT: if (w_conv_done) w_next_state = ST_RUN;
                ST_RUN:     w_next_state = ST_RUN;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_signal        <= 1'b0;
            r_acc           <= '0;
            r_win           <= '0;
            r_update_period <= BITS'(UPDATE_PERIOD);
            r_active_period <= BITS'(UPDATE_PERIOD);
        end else begin
            if (period_load && (period >= BITS'(2))) begin
                r_update_period <= period;
            end
            if (load) begin
                r_signal <= 1'b0;
            end else begin
                case (r_state)
                    ST_CONVERT: begin
                        if (w_conv_done) begin
                            r_win           <= '0;
                            r_acc           <= '0;
                            r_signal        <= 1'b0;
                            r_active_period <= r_update_period;
                        end
                    end
                    ST_RUN: begin
                        if (w_window_end) begin
                            r_win           <= '0;
                            r_acc           <= '0;
                            r_signal        <= 1'b0;
                            r_active_period <= r_update_period;
                        end else begin
                            r_win <= r_win + BITS'(1);
                            if (w_sum >= w_period_ext) begin
                                // Saturated: keep acc at zero so it can never overflow.
                                r_acc    <= w_saturated ? '0 : w_remainder;
                                r_signal <= ~r_signal;
                            end else begin
                                r_acc <= w_sum[BITS-1:0];
                            end
                        end
                    end
                    default: r_signal <= 1'b0;
                endcase
            end
        end
    end

    assign signal       = r_signal;
    assign busy         = (r_state == ST_CONVERT);
    assign window_start = (r_state == ST_RUN) && (r_win == '0);

endmodule
